lfsr_stream_checker: RTL

- Receive-side counterpart of the 22-bit XNOR LFSR pattern generator.
- Accepts the generator's serial bit stream one bit per qualified cycle and self-synchronises to it.
- Reports lock status, per-bit error pulses and a saturating error count for LED/debug display.
- Sits downstream of the generator, or of a loopback path, in the same clock domain.

---
 rtl/lfsr_stream_checker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 22-bit XNOR LFSR pattern stream: HUNT -> VERIFY -> LOCKED.
// Optional macro LFSR_CHECK_FLYWHEEL_EN: while locked, the shift register runs on predicted bits.
module lfsr_stream_checker #(
    parameter int WIDTH       = 22,
    parameter int TAP_A       = 21,
    parameter int TAP_B       = 20,
    parameter int LOCK_COUNT  = 32,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic                 i_bit,
    input  logic                 i_clr_count,
    output logic                 o_locked,
    output logic                 o_err_pulse,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic [1:0]           o_state
);

    localparam int FILL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int CONS_W  = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [CONS_W-1:0]  CONS_LAST  = CONS_W'(UNLOCK_ERRS - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       sr_q, sr_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [MATCH_W-1:0]     match_q, match_d;
    logic [CONS_W-1:0]      cons_q, cons_d;
    logic                   err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                   pred;
    logic                   mismatch;
    logic [WIDTH-1:0]       shifted;

    // i_valid is a pure qualifier (no back-pressure): a bit is consumed on every
    // rising edge where i_valid=1, and nothing but the count clear moves otherwise.
    assign pred     = ~(sr_q[TAP_A] ^ sr_q[TAP_B]);
    assign mismatch = (i_bit != pred);
    assign shifted  = {sr_q[WIDTH-2:0], i_bit};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            cons_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            cons_q      <= cons_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        cons_d      = cons_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (i_valid) begin
            case (state_q)
                HUNT: begin
                    sr_d = shifted;
                    if (fill_q == FILL_LAST) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    sr_d = shifted;
                    // All-ones is the XNOR lockup point; the generator can never emit it.
                    if (mismatch || (shifted == '1)) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (match_q == MATCH_LAST) begin
                        state_d = LOCKED;
                        cons_d  = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end
                LOCKED: begin
`ifdef LFSR_CHECK_FLYWHEEL_EN
                    sr_d = {sr_q[WIDTH-2:0], pred};
`else
                    sr_d = shifted;
`endif
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                        if (cons_q == CONS_LAST) begin
                            state_d = HUNT;
                            fill_d  = '0;
                            cons_d  = '0;
                        end else begin
                            cons_d = cons_q + CONS_W'(1);
                        end
                    end else begin
                        cons_d = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase
        end

        // Debug clear acts whether or not a bit is qualified, and beats a same-cycle error.
        if (i_clr_count) begin
            err_cnt_d = '0;
        end
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_err_pulse = err_pulse_q;
    assign o_err_count = err_cnt_q;
    assign o_state     = state_q;

endmodule
